// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port, memory port and status signals around the
// unified-memory arbiter. The master side is the environment, slave is the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and memory-stage (D) ports onto one single-ported
// memory, one transaction at a time, D first with a starvation guard for I.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_RESP_I = 3'd3,
        S_RESP_D = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;

    logic starve_full;
    logic grant_i, grant_d;

    assign starve_full = (starve_q == CW'(STARVE_MAX));
    assign grant_i     = (state_q == S_IDLE) && (state_d == S_BUSY_I);
    assign grant_d     = (state_q == S_IDLE) && (state_d == S_BUSY_D);

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: D wins contention unless I has been passed over STARVE_MAX times.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.d_req && !(bus.i_req && starve_full)) state_d = S_BUSY_D;
                else if (bus.i_req)                           state_d = S_BUSY_I;
            end
            S_BUSY_I: if (bus.mem_ack) state_d = S_RESP_I;
            S_BUSY_D: if (bus.mem_ack) state_d = S_RESP_D;
            S_RESP_I: state_d = S_IDLE;
            S_RESP_D: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output register inputs, derived from the current and upcoming state.
    always_comb begin
        starve_d    = starve_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = (state_d == S_BUSY_I) || (state_d == S_BUSY_D);
        busy_d      = (state_d != S_IDLE);
        i_ack_d     = (state_d == S_RESP_I);
        d_ack_d     = (state_d == S_RESP_D);

        if (grant_d) begin
            mem_addr_d  = bus.d_addr;
            mem_we_d    = bus.d_we;
            mem_wdata_d = bus.d_wdata;
            if (!bus.i_req)      starve_d = '0;
            else if (!starve_full) starve_d = starve_q + CW'(1);
        end
        if (grant_i) begin
            mem_addr_d = bus.i_addr;
            mem_we_d   = 1'b0;
            starve_d   = '0;
        end
        if (state_q == S_BUSY_I && bus.mem_ack) begin
            i_rdata_d = bus.mem_rdata;
            mem_we_d  = 1'b0;
        end
        if (state_q == S_BUSY_D && bus.mem_ack) begin
            d_rdata_d = bus.mem_rdata;
            mem_we_d  = 1'b0;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from an IDLE cycle: grant, immediate mem_ack, response, back to IDLE.
    task automatic do_grant(input logic exp_d, input logic [31:0] exp_addr,
                            input logic [31:0] rd, input string tag);
        tick();
        check({tag, "_mreq"}, 64'(bus.mem_req), 64'd1);
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'(exp_addr));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ack = 1'b0;
        check({tag, "_dack"}, 64'(bus.d_ack), 64'(exp_d));
        check({tag, "_iack"}, 64'(bus.i_ack), 64'(!exp_d));
        if (exp_d) check({tag, "_drd"}, 64'(bus.d_rdata), 64'(rd));
        else       check({tag, "_ird"}, 64'(bus.i_rdata), 64'(rd));
        tick();
    endtask

    initial begin
        bit exp_seq [10];
        checks   = 0;
        failures = 0;
        reset         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_mreq",  64'(bus.mem_req),   64'd0);
        check("rst_mwe",   64'(bus.mem_we),    64'd0);
        check("rst_maddr", 64'(bus.mem_addr),  64'd0);
        check("rst_mwd",   64'(bus.mem_wdata), 64'd0);
        check("rst_iack",  64'(bus.i_ack),     64'd0);
        check("rst_dack",  64'(bus.d_ack),     64'd0);
        check("rst_ird",   64'(bus.i_rdata),   64'd0);
        check("rst_drd",   64'(bus.d_rdata),   64'd0);
        check("rst_busy",  64'(bus.busy),      64'd0);
        reset = 1'b1;
        tick();

        // single fetch, memory answers after two BUSY cycles
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0040;
        tick();
        check("f_mreq", 64'(bus.mem_req), 64'd1);
        check("f_addr", 64'(bus.mem_addr), 64'h40);
        check("f_we",   64'(bus.mem_we), 64'd0);
        check("f_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("f_wait%0d_mreq", i), 64'(bus.mem_req), 64'd1);
            check($sformatf("f_wait%0d_iack", i), 64'(bus.i_ack), 64'd0);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h2008_0005;
        tick();
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        check("f_iack",  64'(bus.i_ack), 64'd1);
        check("f_dack",  64'(bus.d_ack), 64'd0);
        check("f_ird",   64'(bus.i_rdata), 64'h2008_0005);
        check("f_mreq0", 64'(bus.mem_req), 64'd0);
        tick();
        check("f_iack_end", 64'(bus.i_ack), 64'd0);
        check("f_ird_hold", 64'(bus.i_rdata), 64'h2008_0005);
        check("f_idle",     64'(bus.busy), 64'd0);

        // store with immediate mem_ack
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h54;
        bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        check("s_we",    64'(bus.mem_we), 64'd1);
        check("s_wd",    64'(bus.mem_wdata), 64'hDEAD_BEEF);
        check("s_addr",  64'(bus.mem_addr), 64'h54);
        check("s_dack0", 64'(bus.d_ack), 64'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        check("s_dack", 64'(bus.d_ack), 64'd1);
        check("s_we0",  64'(bus.mem_we), 64'd0);
        tick();
        check("s_dack_end", 64'(bus.d_ack), 64'd0);

        // contention: D,D,D,D,I,D,D,D,D,I
        exp_seq    = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h200;
        for (int g = 0; g < 10; g++)
            do_grant(exp_seq[g], exp_seq[g] ? 32'h200 : 32'h100, 32'h1000 + 32'(g),
                     $sformatf("c%0d", g));

        // priority reset: two contested D, two uncontested D clear the count, then D x4, I
        do_grant(1'b1, 32'h200, 32'hA0, "p_pre0");
        do_grant(1'b1, 32'h200, 32'hA1, "p_pre1");
        bus.i_req = 1'b0;
        do_grant(1'b1, 32'h200, 32'hA2, "p_solo0");
        do_grant(1'b1, 32'h200, 32'hA3, "p_solo1");
        bus.i_req = 1'b1;
        for (int g = 0; g < 4; g++)
            do_grant(1'b1, 32'h200, 32'hB0 + 32'(g), $sformatf("p_d%0d", g));
        do_grant(1'b0, 32'h100, 32'hC0, "p_i");
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;

        // reset in the middle of a BUSY_D transaction
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h300;
        tick();
        check("r_mreq1", 64'(bus.mem_req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("r_mreq0", 64'(bus.mem_req), 64'd0);
        check("r_busy0", 64'(bus.busy), 64'd0);
        check("r_dack0", 64'(bus.d_ack), 64'd0);
        tick();
        bus.d_req   = 1'b0;
        reset       = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("r_stray_dack", 64'(bus.d_ack), 64'd0);
        check("r_stray_iack", 64'(bus.i_ack), 64'd0);
        check("r_stray_busy", 64'(bus.busy), 64'd0);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h44;
        do_grant(1'b0, 32'h44, 32'h1234_5678, "r_post");
        bus.i_req = 1'b0;

        // stray ack in IDLE leaves everything alone
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h48;
        do_grant(1'b1, 32'h48, 32'hCAFE_F00D, "x_load");
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack = 1'b0;
        check("x_iack", 64'(bus.i_ack), 64'd0);
        check("x_dack", 64'(bus.d_ack), 64'd0);
        check("x_busy", 64'(bus.busy), 64'd0);
        check("x_mreq", 64'(bus.mem_req), 64'd0);
        tick();
        check("x_busy2", 64'(bus.busy), 64'd0);
        check("x_ird",   64'(bus.i_rdata), 64'h1234_5678);
        check("x_drd",   64'(bus.d_rdata), 64'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
